// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding, PC select codes,
// the NOP word and the IF/ID payload.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_KILL  = 2'b10,
        S_HOLD  = 2'b11
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_HOLD   = 2'b11
    } pc_sel_e;

    localparam logic [31:0] NOP         = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0000_0000, instr: NOP, valid: 1'b0};

    function automatic logic is_redirect(input logic pc_write, input pc_sel_e pc_sel);
        return pc_write && ((pc_sel == PC_BRANCH) || (pc_sel == PC_JUMP));
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_register.sv
// IF/ID pipeline register: loads a fetched instruction, a bubble, or holds.
// Flush wins over the write enable.
module pc_fetch_unit_if_id_register
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        write_i,
    input  logic        flush_i,
    input  logic        fetch_done_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    if_id_t if_id_d;
    if_id_t if_id_q;

    always_comb begin
        if_id_d = if_id_q;
        if (flush_i) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (write_i && fetch_done_i) begin
            if_id_d = '{pc: pc_i, instr: instr_i, valid: 1'b1};
        end else if (write_i) begin
            if_id_d = IF_ID_BUBBLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign pc_o    = if_id_q.pc;
    assign instr_o = if_id_q.instr;
    assign valid_o = if_id_q.valid;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack FSM with stale-fetch kill and a one-entry buffer.
// Define FETCH_PERF_CNT_EN to add the saturating stall-cycle and kill counters.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic [1:0]  pc_mux_select,
    input  logic        if_id_write,
    input  logic        if_id_flush,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_stall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_kills
`endif
);

    fetch_state_e state_d;
    fetch_state_e state_q;
    logic [31:0]  pc_d;
    logic [31:0]  pc_q;
    logic [31:0]  kill_addr_d;
    logic [31:0]  kill_addr_q;
    logic [31:0]  buf_d;
    logic [31:0]  buf_q;

    pc_sel_e      pc_sel;
    logic         redirect;
    logic         fetch_done;
    logic         seq_advance;
    logic         capture;
    logic [31:0]  redirect_target;
    logic [31:0]  fetch_word;

    assign pc_sel          = pc_sel_e'(pc_mux_select);
    assign redirect        = is_redirect(pc_write, pc_sel);
    assign fetch_done      = ((state_q == S_FETCH) && imem_ack) || (state_q == S_HOLD);
    assign fetch_word      = (state_q == S_HOLD) ? buf_q : imem_rdata;
    assign seq_advance     = pc_write && (pc_sel == PC_SEQ) && if_id_write && fetch_done;
    assign capture         = (state_q == S_FETCH) && imem_ack && (!if_id_write || !pc_write);
    assign redirect_target = (pc_sel == PC_BRANCH) ? branch_target : jump_target;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_addr_d = kill_addr_q;
        buf_d       = buf_q;

        if (redirect) begin
            pc_d = redirect_target;
            unique case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        state_d = S_FETCH;
                    end else begin
                        // The memory still owes us this word; remember where it was sent.
                        state_d     = S_KILL;
                        kill_addr_d = pc_q;
                    end
                end
                S_KILL:  state_d = imem_ack ? S_FETCH : S_KILL;
                S_HOLD:  state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_KILL: begin
                    if (imem_ack) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH, S_HOLD: begin
                    if (seq_advance) begin
                        pc_d    = pc_q + INSTR_BYTES;
                        state_d = S_FETCH;
                    end else if (capture) begin
                        buf_d   = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            kill_addr_q <= 32'h0000_0000;
            buf_q       <= NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_addr_q <= kill_addr_d;
            buf_q       <= buf_d;
        end
    end

    always_comb begin
        imem_req    = (state_q == S_FETCH) || (state_q == S_KILL);
        imem_addr   = (state_q == S_KILL) ? kill_addr_q : pc_q;
        fetch_stall = !fetch_done;
    end

    pc_fetch_unit_if_id_register u_if_id (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .write_i      (if_id_write),
        .flush_i      (if_id_flush),
        .fetch_done_i (fetch_done),
        .pc_i         (pc_q),
        .instr_i      (fetch_word),
        .pc_o         (if_id_pc),
        .instr_o      (if_id_instr),
        .valid_o      (if_id_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] kill_cnt_d;
    logic [31:0] kill_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (fetch_stall && (state_q != S_IDLE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((state_q == S_FETCH) && (state_d == S_KILL) && (kill_cnt_q != 32'hFFFF_FFFF)) begin
            kill_cnt_d = kill_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'h0000_0000;
            kill_cnt_q  <= 32'h0000_0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_kills        = kill_cnt_q;
`endif

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Instruction-fetch stage of the 5-stage pipeline. Holds the PC and fetches from instruction memory over a req/ack handshake, then loads the IF/ID pipeline register.
- Consumes the stall, redirect and flush controls produced by the hazard detection unit.
- Absorbs multi-cycle memory latency, discards fetches made stale by a redirect, and inserts bubbles into IF/ID when no instruction is ready.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  pipeline clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- pc_write  in  1  hazard unit PC_Write; 0 = hold PC (load-use stall)
- pc_mux_select  in  2  00 = PC+4, 01 = branch_target, 10 = jump_target, 11 = hold
- if_id_write  in  1  hazard unit IF_ID_Write; 0 = freeze IF/ID
- if_id_flush  in  1  hazard unit IF_ID_Mux_select; 1 = load bubble into IF/ID
- branch_target  in  32  redirect address for select 01
- jump_target  in  32  redirect address for select 10
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_ack  in  1  data valid this cycle; may arrive in the same cycle as imem_req (zero-wait)
- imem_rdata  in  32  instruction word, valid with imem_ack
- if_id_pc  out  32  PC of the instruction in IF/ID
- if_id_instr  out  32  instruction in IF/ID; 32'h0000_0000 (NOP) when bubble
- if_id_valid  out  1  IF/ID holds a real instruction
- fetch_stall  out  1  IF has no instruction ready this cycle

## Operation
- FSM states:
  - S_IDLE: post-reset cycle, imem_req=0.
  - S_FETCH: request outstanding for the current PC.
  - S_KILL: stale request outstanding; its data is discarded.
  - S_HOLD: instruction is captured in a one-entry fetch buffer and waits for if_id_write.
- fetch_done = (S_FETCH && imem_ack) || S_HOLD. fetch_stall = !fetch_done.
- redirect = pc_write && (pc_mux_select == 01 || pc_mux_select == 10).
- Priority each cycle: reset > redirect/flush > sequential.
- Redirect:
  - pc <= selected target.
  - Buffer is dropped.
  - S_FETCH without ack -> S_KILL.
  - S_FETCH with ack, or S_HOLD -> S_FETCH at the new PC.
  - S_KILL stays in S_KILL.
- S_KILL:
  - imem_req stays 1 with the old address; the protocol never abandons a request.
  - On imem_ack the data is dropped and the FSM moves to S_FETCH.
- Sequential advance: pc_write && pc_mux_select==00 && if_id_write && fetch_done -> pc <= pc+4, then S_FETCH.
  - 32-bit wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- S_FETCH with ack while if_id_write=0 or pc_write=0: data is latched into the buffer, FSM -> S_HOLD, PC held.
- pc_mux_select 11 with pc_write=1: PC held, fetch state unchanged.
- IF/ID update:
  - if_id_flush=1 -> valid=0, instr=NOP, pc=0, regardless of if_id_write.
  - Else if_id_write && fetch_done -> {pc, instruction, 1}.
  - Else if_id_write && !fetch_done -> bubble.
  - Else hold.
- Reset values: pc=RESET_PC, state=S_IDLE, buffer empty, if_id_pc=0, if_id_instr=0, if_id_valid=0, imem_req=0, fetch_stall=1.
- Reset while a request is outstanding: FSM returns to S_IDLE. The instruction memory is reset by the same rst_n, so no stale ack follows.

## Timing
- Zero-wait memory: one instruction per cycle.
  - Cycle n: imem_req=1 and imem_ack=1. At the clock edge closing cycle n, if_id_instr is loaded.
  - Cycle n+1: imem_addr = PC+4.
- First fetch: imem_req rises in the first cycle after rst_n goes high, with imem_addr=RESET_PC.
- Redirect penalty:
  - 1 bubble with zero-wait memory.
  - 1 + remaining stale latency when in S_KILL.
- imem_req, imem_addr and fetch_stall are decoded from state and pc only (Moore); no input-to-output combinational path except through fetch_done.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - adds outputs perf_stall_cycles[31:0] (cycles with fetch_stall=1 outside S_IDLE) and perf_kills[31:0] (requests entering S_KILL).
  - Both are saturating and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- The shared define file holds:
  - state encodings S_IDLE=2'b00, S_FETCH=2'b01, S_KILL=2'b10, S_HOLD=2'b11;
  - PC select codes PC_SEQ, PC_BRANCH, PC_JUMP, PC_HOLD;
  - the NOP constant 32'h0000_0000.
- Sub-module if_id_register: write/flush/hold of {pc, instr, valid}.
- The PC, FSM and buffer stay in the top module.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1 -> imem_req=0 and if_id_valid=0 during reset; next cycle imem_addr=32'h0 and imem_req=1.
- Zero-wait stream: ack always 1, controls sequential -> if_id_pc=0, 4, 8, 12 on consecutive cycles, all with if_id_valid=1.
- Latency 3: ack 3 cycles after req -> fetch_stall=1 for 2 cycles, two bubbles into IF/ID, then if_id_instr = rdata of addr 0.
- Redirect mid-fetch: request to 0x10 outstanding, branch to 0x100 -> addr 0x10 held until ack, data dropped; next req addr=0x100, and the dropped word is never in IF/ID.
- Load-use stall: pc_write=0 and if_id_write=0 for 1 cycle during an acked fetch -> S_HOLD. IF/ID holds, then loads the buffered word with pc=0x8, and the PC advances to 0xC.
- Wrap: RESET_PC=32'hFFFF_FFFC, sequential -> second imem_addr=32'h0000_0000.
